// File: rtl/keypad_scan16_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scan16_if : keypad matrix pins and the CPU-facing entry word   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface keypad_scan16_if;
   logic [3:0]  keyCol;
   logic        clear;
   logic [3:0]  keyRow;
   logic [31:0] keyData;
   logic [3:0]  keyCode;
   logic        keyValid;

   modport master (
      output keyCol,
      output clear,
      input  keyRow,
      input  keyData,
      input  keyCode,
      input  keyValid
   );

   modport slave (
      input  keyCol,
      input  clear,
      output keyRow,
      output keyData,
      output keyCode,
      output keyValid
   );
endinterface
`default_nettype wire

// File: rtl/keypad_scan16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scan16 : 4x4 hex keypad scanner, debouncer and digit shifter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module keypad_scan16 #(
   parameter int SCAN_DIV       = 16384,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  wire logic      CLK,
   input  wire logic      RST,
   keypad_scan16_if.slave kp
);
   localparam int               DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DB_TARGET = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       sync1_q;
   logic [3:0]       col_s_q;
   logic [DIV_W-1:0] div_q;
   logic [3:0]       row_q, row_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       db_cnt_q, db_cnt_d;
   logic [3:0]       rel_cnt_q, rel_cnt_d;
   logic [31:0]      data_q, data_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q;

   logic             tick;
   logic             single;
   logic [1:0]       col_now;
   logic [1:0]       row_idx;
   logic [3:0]       row_next;
   logic [3:0]       db_inc;
   logic [3:0]       rel_inc;
   logic             accept;
   logic [1:0]       accept_col;
   logic [3:0]       code_new;

   assign tick     = (div_q == DIV_LAST);
   assign row_next = {row_q[2:0], row_q[3]};
   assign db_inc   = db_cnt_q + 4'd1;
   assign rel_inc  = rel_cnt_q + 4'd1;
   assign code_new = {row_idx, accept_col};

   // A sample counts as a press only when exactly one column is pulled low.
   always_comb begin
      single  = 1'b1;
      col_now = 2'd0;
      case (col_s_q)
         4'b1110: col_now = 2'd0;
         4'b1101: col_now = 2'd1;
         4'b1011: col_now = 2'd2;
         4'b0111: col_now = 2'd3;
         default: single  = 1'b0;
      endcase
   end

   always_comb begin
      row_idx = 2'd0;
      case (row_q)
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_idx_d  = col_idx_q;
      db_cnt_d   = db_cnt_q;
      rel_cnt_d  = rel_cnt_q;
      accept     = 1'b0;
      accept_col = col_idx_q;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (single) begin
                  col_idx_d = col_now;
                  db_cnt_d  = 4'd1;
                  if (DB_TARGET == 4'd1) begin
                     accept     = 1'b1;
                     accept_col = col_now;
                     rel_cnt_d  = 4'd0;
                     state_d    = ST_HELD;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end else begin
                  row_d = row_next;
               end
            end
            ST_DEBOUNCE: begin
               if (single && (col_now == col_idx_q)) begin
                  db_cnt_d = db_inc;
                  if (db_inc == DB_TARGET) begin
                     accept    = 1'b1;
                     rel_cnt_d = 4'd0;
                     state_d   = ST_HELD;
                  end
               end else begin
                  row_d   = row_next;
                  state_d = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (col_s_q == 4'b1111) begin
                  if (rel_inc == DB_TARGET) begin
                     rel_cnt_d = 4'd0;
                     row_d     = row_next;
                     state_d   = ST_SCAN;
                  end else begin
                     rel_cnt_d = rel_inc;
                  end
               end else begin
                  rel_cnt_d = 4'd0;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
   end

   // A coincident clear wins over the old digits but not over the new one.
   always_comb begin
      data_d = data_q;
      code_d = code_q;
      if (accept) begin
         code_d = code_new;
         data_d = kp.clear ? {28'h0, code_new} : {data_q[27:0], code_new};
      end else if (kp.clear) begin
         data_d = 32'h0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q   <= 4'b1111;
         col_s_q   <= 4'b1111;
         div_q     <= '0;
         state_q   <= ST_SCAN;
         row_q     <= 4'b1110;
         col_idx_q <= 2'd0;
         db_cnt_q  <= 4'd0;
         rel_cnt_q <= 4'd0;
         data_q    <= 32'h0;
         code_q    <= 4'h0;
         valid_q   <= 1'b0;
      end else begin
         sync1_q   <= kp.keyCol;
         col_s_q   <= sync1_q;
         div_q     <= tick ? '0 : div_q + DIV_W'(1);
         state_q   <= state_d;
         row_q     <= row_d;
         col_idx_q <= col_idx_d;
         db_cnt_q  <= db_cnt_d;
         rel_cnt_q <= rel_cnt_d;
         data_q    <= data_d;
         code_q    <= code_d;
         valid_q   <= accept;
      end
   end

   assign kp.keyRow   = row_q;
   assign kp.keyData  = data_q;
   assign kp.keyCode  = code_q;
   assign kp.keyValid = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_scan16 : bench for keypad_scan16 with a 4x4 matrix model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_keypad_scan16;
   logic        clk;
   logic        rst;
   logic [15:0] pressed;
   int          n_cmp;
   int          n_bad;
   logic [3:0]  digits[$];

   keypad_scan16_if ifc();

   keypad_scan16 #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .kp  (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Switch matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      logic [3:0] col;
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!ifc.keyRow[r] && pressed[4*r+c]) col[c] = 1'b0;
      ifc.keyCol = col;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] mask_a;
      int          t_b;
      logic [15:0] mask_b;
      int          n_cyc;
      int          exp_pulses;
      int          exp_first;
      logic [3:0]  exp_code;
      logic [3:0]  exp_row;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_data();
      logic [31:0] v;
      v = 32'h0;
      foreach (digits[i]) v = (v << 4) | 32'(digits[i]);
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      pressed   = 16'h0;
      ifc.clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      digits.delete();
   endtask

   task automatic press_key(input int k, input int hold_extra);
      int waited;
      int extra;
      bit seen;
      pressed = 16'(1 << k);
      seen    = 1'b0;
      waited  = 0;
      while (!seen && waited < 100) begin
         @(negedge clk);
         waited++;
         if (ifc.keyValid) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL press timeout: key %0d produced no keyValid", k);
      end else begin
         digits.push_back(4'(k));
         check("press keyCode", 32'(ifc.keyCode), 32'(k));
         check("press keyData", ifc.keyData, model_data());
      end
      extra = 0;
      repeat (hold_extra) begin
         @(negedge clk);
         if (ifc.keyValid) extra++;
      end
      pressed = 16'h0;
      repeat (24) begin
         @(negedge clk);
         if (ifc.keyValid) extra++;
      end
      check("press extra pulses", 32'(extra), 32'd0);
   endtask

   initial begin
      int         cnt;
      int         first;
      logic [3:0] prev_row;
      bit         found;
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      pressed   = 16'h0;
      ifc.clear = 1'b0;

      vecs[0] = '{16'h0200, 999, 16'h0000,  20, 1, 16, 4'h9, 4'b1011};
      vecs[1] = '{16'h0001, 999, 16'h0000,  40, 1,  8, 4'h0, 4'b1110};
      vecs[2] = '{16'h0040, 999, 16'h0000,  30, 1, 12, 4'h6, 4'b1101};
      vecs[3] = '{16'h8000, 999, 16'h0000, 220, 1, 20, 4'hF, 4'b0111};
      vecs[4] = '{16'h0001,   3, 16'h0000,   8, 0, -1, 4'h0, 4'b1101};
      vecs[5] = '{16'h0001,   3, 16'h0002,   8, 0, -1, 4'h0, 4'b1101};
      vecs[6] = '{16'h0003, 999, 16'h0000,  40, 0, -1, 4'h0, 4'b1011};

      // Reset values and the idle row walk.
      do_reset();
      check("reset keyRow", 32'(ifc.keyRow), 32'b1110);
      check("reset keyData", ifc.keyData, 32'h0);
      check("reset keyCode", 32'(ifc.keyCode), 32'h0);
      check("reset keyValid", 32'(ifc.keyValid), 32'h0);
      for (int k = 1; k < 16; k++) begin
         logic [3:0] er;
         @(negedge clk);
         er = 4'b1110;
         for (int s = 0; s < k / 4; s++) er = {er[2:0], er[3]};
         check("idle row walk", 32'(ifc.keyRow), 32'(er));
      end

      // Press scenarios started from reset, each with exact timing.
      for (int v = 0; v < 7; v++) begin
         do_reset();
         pressed = vecs[v].mask_a;
         cnt     = 0;
         first   = -1;
         for (int cyc = 1; cyc <= vecs[v].n_cyc; cyc++) begin
            @(negedge clk);
            if (cyc == vecs[v].t_b) pressed = vecs[v].mask_b;
            if (ifc.keyValid) begin
               cnt++;
               if (first < 0) first = cyc;
            end
         end
         check($sformatf("vec%0d pulses", v), 32'(cnt), 32'(vecs[v].exp_pulses));
         check($sformatf("vec%0d first pulse cycle", v), 32'(first), 32'(vecs[v].exp_first));
         check($sformatf("vec%0d keyCode", v), 32'(ifc.keyCode), 32'(vecs[v].exp_code));
         check($sformatf("vec%0d keyData", v), ifc.keyData,
               (vecs[v].exp_pulses > 0) ? 32'(vecs[v].exp_code) : 32'h0);
         check($sformatf("vec%0d keyRow", v), 32'(ifc.keyRow), 32'(vecs[v].exp_row));
      end

      // Release debounce: row stays frozen until two all-high ticks.
      do_reset();
      pressed = 16'h0200;
      cnt     = 0;
      for (int cyc = 1; cyc <= 32; cyc++) begin
         @(negedge clk);
         if (cyc == 24) pressed = 16'h0;
         if (ifc.keyValid) cnt++;
         if (cyc == 31) check("row frozen before release accepted", 32'(ifc.keyRow), 32'b1011);
         if (cyc == 32) check("row advances after release", 32'(ifc.keyRow), 32'b0111);
      end
      check("release test pulses", 32'(cnt), 32'd1);

      // Reset in the middle of debouncing abandons the press.
      do_reset();
      pressed = 16'h0001;
      cnt     = 0;
      repeat (5) begin
         @(negedge clk);
         if (ifc.keyValid) cnt++;
      end
      rst     = 1'b1;
      pressed = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset mid-debounce keyRow", 32'(ifc.keyRow), 32'b1110);
      repeat (30) begin
         @(negedge clk);
         if (ifc.keyValid) cnt++;
      end
      check("reset mid-debounce pulses", 32'(cnt), 32'd0);

      // Digit entry and the shift boundary.
      do_reset();
      for (int k = 1; k <= 8; k++) press_key(k, 3);
      check("eight digits", ifc.keyData, 32'h12345678);
      press_key(10, 5);
      check("ninth digit shifts", ifc.keyData, 32'h2345678A);

      // Clear on its own.
      @(negedge clk);
      ifc.clear = 1'b1;
      @(negedge clk);
      ifc.clear = 1'b0;
      digits.delete();
      check("clear keyData", ifc.keyData, 32'h0);
      check("clear keeps keyCode", 32'(ifc.keyCode), 32'hA);

      // Clear in the same cycle as the accept of key 5.
      press_key(1, 2);
      press_key(2, 2);
      prev_row = ifc.keyRow;
      found    = 1'b0;
      for (int w = 0; w < 64 && !found; w++) begin
         @(negedge clk);
         if (ifc.keyRow == 4'b1101 && prev_row != 4'b1101) found = 1'b1;
         prev_row = ifc.keyRow;
      end
      check("row1 entry seen", 32'(found), 32'd1);
      pressed = 16'h0020;
      repeat (7) @(negedge clk);
      ifc.clear = 1'b1;
      @(negedge clk);
      ifc.clear = 1'b0;
      check("clear+accept keyValid", 32'(ifc.keyValid), 32'd1);
      check("clear+accept keyCode", 32'(ifc.keyCode), 32'h5);
      check("clear+accept keyData", ifc.keyData, 32'h00000005);
      digits.delete();
      digits.push_back(4'h5);
      pressed = 16'h0;
      repeat (24) @(negedge clk);

      // Random presses, glitches and clears against the digit-queue model.
      for (int it = 0; it < 24; it++) begin
         int act;
         act = int'($urandom_range(0, 9));
         if (act <= 5) begin
            press_key(int'($urandom_range(0, 15)), int'($urandom_range(0, 30)));
         end else if (act <= 7) begin
            cnt     = 0;
            pressed = 16'(1 << $urandom_range(0, 15));
            repeat ($urandom_range(1, 4)) begin
               @(negedge clk);
               if (ifc.keyValid) cnt++;
            end
            pressed = 16'h0;
            repeat (12) begin
               @(negedge clk);
               if (ifc.keyValid) cnt++;
            end
            check("glitch pulses", 32'(cnt), 32'd0);
            check("glitch keyData", ifc.keyData, model_data());
         end else begin
            @(negedge clk);
            ifc.clear = 1'b1;
            @(negedge clk);
            ifc.clear = 1'b0;
            digits.delete();
            check("random clear keyData", ifc.keyData, model_data());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
